// File: rtl/stack_engine.sv
// Hardware stack unit: PUSH/POP/PEEK/CLEAR over valid/ready, downward-growing SP,
// storage in a synchronous-read RAM, with overflow/underflow reporting.
module stack_engine #(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 16,
  parameter int                DEPTH  = 16,
  parameter logic [ADDR_W-1:0] BASE   = 16'hF3FF,
  localparam int               CW     = $clog2(DEPTH + 1),
  localparam int               IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] sp,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;

  state_t            state_reg;
  logic [CW-1:0]     count_reg;
  logic [ADDR_W-1:0] sp_reg;
  logic [IW-1:0]     rd_addr_reg;
  logic [DATA_W-1:0] ram_q_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              wr_en;
  logic [IW-1:0]     wr_addr;
  logic [IW-1:0]     top_addr;

  assign req_ready = (state_reg == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign sp        = sp_reg;
  assign wr_addr   = IW'(count_reg);
  assign top_addr  = IW'(count_reg - CW'(1));
  assign wr_en     = accept && (req_op == OP_PUSH) && !full;

  // Storage has no reset so it maps onto block RAM; read data is registered.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= req_data;
    end
    ram_q_reg <= mem[rd_addr_reg];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      sp_reg      <= BASE;
      rd_addr_reg <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            case (req_op)
              OP_PUSH: begin
                resp_valid <= 1'b1;
                if (full) begin
                  resp_err  <= 1'b1;
                  resp_data <= '0;
                end else begin
                  resp_err  <= 1'b0;
                  resp_data <= req_data;
                  count_reg <= count_reg + CW'(1);
                  sp_reg    <= sp_reg - ADDR_W'(1);
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_data  <= '0;
                end else begin
                  // Address taken from the pre-update count; POP retires the entry now.
                  rd_addr_reg <= top_addr;
                  state_reg   <= RD1;
                  if (req_op == OP_POP) begin
                    count_reg <= count_reg - CW'(1);
                    sp_reg    <= sp_reg + ADDR_W'(1);
                  end
                end
              end
              default: begin
                count_reg  <= '0;
                sp_reg     <= BASE;
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_data  <= '0;
              end
            endcase
          end
        end
        RD1: state_reg <= RD2;
        RD2: begin
          state_reg  <= IDLE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= ram_q_reg;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
